sdram_frame_reader: RTL and testbench
=====================================

Name: sdram_frame_reader

Overview:
Reads one full frame of pixels back out of SDRAM, the read-side counterpart of the frame loader that writes ROM pixels into SDRAM. It puts the SDRAM controller into read mode and accepts the sequential word stream. Words are buffered in a small FIFO and presented to a downstream consumer (VGA/BEV pipeline) over valid/ready, tagged with x/y coordinates. Sits between the SDRAM controller read port and the display/processing datapath.

Parameters:
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
DATA_WIDTH, 16, SDRAM word width
PIX_WIDTH, 3, pixel bits taken from word LSBs
FIFO_DEPTH, 16, buffer entries (power of 2, >=4)
PAUSE_MARGIN, 4, free-entry threshold for read_pause

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_reading  in  1  request to read one frame (sampled in IDLE only)
sdram_ready  in  1  SDRAM controller initialised
enable_read_mode  out  1  puts controller in sequential read mode
sdram_rx_valid  in  1  one-cycle strobe: sdram_rx_data holds next word
sdram_rx_data  in  DATA_WIDTH  read word
read_pause  out  1  backpressure request to controller
pix_valid  out  1  pix_* hold a valid pixel
pix_ready  in  1  consumer accepts pixel
pix_data  out  PIX_WIDTH  sdram_rx_data[PIX_WIDTH-1:0] of head word
pix_x  out  9  column of head pixel
pix_y  out  8  row of head pixel
pix_last  out  1  head pixel is (IMG_WIDTH-1, IMG_HEIGHT-1)
reading_complete  out  1  one-cycle pulse, frame fully delivered
overflow_err  out  1  sticky: a word arrived with FIFO full

Behaviour:
- Reset (async, rst_n low): state IDLE. All counters, FIFO pointers and overflow_err are 0. Every output is 0. Reset mid-frame aborts immediately; no completion pulse.
- TOTAL_PIXELS = IMG_WIDTH*IMG_HEIGHT. rx_count and tx_count are 18-bit.
- IDLE: if start_reading && sdram_ready -> REQ. On that edge, clear rx_count, tx_count, x/y, FIFO and overflow_err. start_reading is ignored in any other state.
- REQ: enable_read_mode=1. The first sdram_rx_valid -> STREAM; that word is accepted.
- STREAM: enable_read_mode=1. Each sdram_rx_valid pushes one word and rx_count++. When the push makes rx_count==TOTAL_PIXELS -> DRAIN; enable_read_mode drops on the next cycle.
- DRAIN: enable_read_mode=0. When tx_count==TOTAL_PIXELS and the FIFO is empty -> DONE.
- DONE: reading_complete=1 for exactly one cycle -> IDLE.
- Words are accepted only in REQ or STREAM with rx_count<TOTAL_PIXELS; all others are discarded silently.
- FIFO is show-ahead. A word pushed at edge N gives pix_valid=1 in the cycle after edge N (1-cycle latency). pix_valid = FIFO not empty.
- Pop occurs when pix_valid && pix_ready. tx_count++ and the coordinates advance: x wraps IMG_WIDTH-1->0 with y++. The coordinates after the last pixel are don't-care until the next start.
- Full FIFO with rx_valid:
  - With a simultaneous pop, the push is accepted and the level is unchanged.
  - Without a pop, the word is dropped, rx_count still increments, and overflow_err is set. overflow_err stays set until the next start.
- Simultaneous push and pop on an empty FIFO: the word is written. pix_valid rises the next cycle. The same-cycle pop is impossible because pix_valid=0.
- read_pause = (FIFO_DEPTH - level) <= PAUSE_MARGIN. It is registered-free combinational from the level.
- pix_valid held with pix_ready=0: pix_data, pix_x, pix_y and pix_last stay stable.

Decomposition:
- Package frame_reader_pkg:
  - state_t enum {IDLE, REQ, STREAM, DRAIN, DONE}, logic [2:0]
  - TOTAL_PIXELS function of width/height
  - coordinate widths
- Sub-module sync_fifo (DEPTH, WIDTH): push/pop/full/empty/level, show-ahead read, same clk/rst_n.

Test Plan:
- Reset behaviour: IMG 4x2, assert rst_n low mid-STREAM after 3 words -> all outputs 0 the same cycle. After release, state IDLE, no reading_complete pulse.
- Basic frame: IMG 4x2, start with sdram_ready=1, 8 strobes of data 0..7, pix_ready=1 -> pix_data 0..7.
  - Coordinates (0,0)..(3,0),(0,1)..(3,1); pix_last only on 7.
  - reading_complete pulses once; enable_read_mode 0 after the 8th word.
- Backpressure: FIFO_DEPTH 8, PAUSE_MARGIN 2, pix_ready=0 -> read_pause rises when level reaches 6. Releasing pix_ready drains in order.
- Overflow: pix_ready=0, 9 strobes into depth-8 FIFO -> overflow_err=1. The 9th word is absent from the output stream. It clears on the next start_reading.
- Gating: start_reading with sdram_ready=0 -> stays IDLE. Strobes in IDLE are ignored. A 9th strobe in DRAIN is not output.
- Same-cycle push+pop with FIFO full -> level unchanged, no overflow, order preserved.

Source files
------------

// File: rtl/sdram_frame_reader_pkg.sv
// Shared types and constants for the SDRAM frame reader.
//   state_t      : frame reader control states
//   X_W / Y_W    : widths of the pixel column / row tags
//   CNT_W        : width of the received / delivered word counters
//   total_pixels : number of pixels in one frame
package frame_reader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int CNT_W = 18;

    function automatic logic [CNT_W-1:0] total_pixels(input int width, input int height);
        return CNT_W'(width * height);
    endfunction

endpackage

// File: rtl/sdram_frame_reader_if.sv
// Bus bundle between the frame reader, the SDRAM controller read port and
// the downstream pixel consumer.
//   SDRAM side : sdram_ready, enable_read_mode, sdram_rx_valid,
//                sdram_rx_data, read_pause
//   Pixel side : pix_valid, pix_ready, pix_data, pix_x, pix_y, pix_last
// The master modport is the frame reader; the slave modport is the
// environment (controller + consumer).
interface sdram_frame_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PIX_WIDTH  = 3
) ();
    import frame_reader_pkg::*;

    logic                  sdram_ready;
    logic                  enable_read_mode;
    logic                  sdram_rx_valid;
    logic [DATA_WIDTH-1:0] sdram_rx_data;
    logic                  read_pause;

    logic                  pix_valid;
    logic                  pix_ready;
    logic [PIX_WIDTH-1:0]  pix_data;
    logic [X_W-1:0]        pix_x;
    logic [Y_W-1:0]        pix_y;
    logic                  pix_last;

    modport master (
        input  sdram_ready,
        input  sdram_rx_valid,
        input  sdram_rx_data,
        input  pix_ready,
        output enable_read_mode,
        output read_pause,
        output pix_valid,
        output pix_data,
        output pix_x,
        output pix_y,
        output pix_last
    );

    modport slave (
        output sdram_ready,
        output sdram_rx_valid,
        output sdram_rx_data,
        output pix_ready,
        input  enable_read_mode,
        input  read_pause,
        input  pix_valid,
        input  pix_data,
        input  pix_x,
        input  pix_y,
        input  pix_last
    );

endinterface

// File: rtl/sdram_frame_reader_fifo.sv
// Show-ahead synchronous FIFO used to buffer SDRAM read words.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   clear      : synchronous flush, priority over push/pop
//   push/wdata : write request; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   rdata      : head entry, valid whenever empty is low
//   full/empty/level : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 3,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign rd_en = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sdram_frame_reader.sv
// Reads one frame of pixels out of SDRAM and streams it to a consumer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_reading     : frame request, honoured only in IDLE with sdram_ready
//   reading_complete  : one-cycle pulse once every pixel has been delivered
//   overflow_err      : sticky, a word arrived while the FIFO was full
//   bus (master)      : SDRAM read port and pixel valid/ready stream
// Words are buffered in a show-ahead FIFO; the x/y tags count delivered
// pixels, so they always describe the current FIFO head.
module sdram_frame_reader
    import frame_reader_pkg::*;
#(
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 240,
    parameter int DATA_WIDTH   = 16,
    parameter int PIX_WIDTH    = 3,
    parameter int FIFO_DEPTH   = 16,
    parameter int PAUSE_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_reading,
    output logic                 reading_complete,
    output logic                 overflow_err,
    sdram_frame_reader_if.master bus
);

    localparam logic [CNT_W-1:0] TOTAL  = total_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam int               LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [X_W-1:0]   X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(IMG_HEIGHT - 1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     rx_count;
    logic [CNT_W-1:0]     tx_count;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic                 overflow_q;
    logic                 enable_rd;

    logic                 start_fire;
    logic                 in_rx_state;
    logic                 accept;
    logic                 rx_final;
    logic                 pop_fire;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;
    logic [PIX_WIDTH-1:0] fifo_rdata;

    // Only the pixel LSBs are kept; the rest of the SDRAM word is dropped.
    logic                 unused_rx_bits;
    assign unused_rx_bits = ^bus.sdram_rx_data[DATA_WIDTH-1:PIX_WIDTH];

    assign start_fire  = (state_q == IDLE) && start_reading && bus.sdram_ready;
    assign in_rx_state = (state_q == REQ) || (state_q == STREAM);
    assign accept      = bus.sdram_rx_valid && in_rx_state && (rx_count < TOTAL);
    assign rx_final    = accept && ((rx_count + CNT_W'(1)) == TOTAL);
    assign pop_fire    = !fifo_empty && bus.pix_ready;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_fire),
        .push  (accept),
        .pop   (bus.pix_ready),
        .wdata (bus.sdram_rx_data[PIX_WIDTH-1:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Frame counters, head coordinates and the sticky overflow flag.
    // A dropped word still counts as received, so after an overflow the
    // delivered count never reaches TOTAL and DRAIN is only left by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count   <= '0;
            tx_count   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            overflow_q <= 1'b0;
        end else if (start_fire) begin
            rx_count   <= '0;
            tx_count   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) rx_count <= rx_count + CNT_W'(1);
            if (accept && fifo_full && !pop_fire) overflow_q <= 1'b1;
            if (pop_fire) begin
                tx_count <= tx_count + CNT_W'(1);
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start_fire) state_d = REQ;
            REQ, STREAM: begin
                if (rx_final)    state_d = DRAIN;
                else if (accept) state_d = STREAM;
            end
            DRAIN:  if ((tx_count == TOTAL) && fifo_empty) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enable_rd        = 1'b0;
        reading_complete = 1'b0;
        case (state_q)
            REQ, STREAM: enable_rd        = 1'b1;
            DONE:        reading_complete = 1'b1;
            default: ;
        endcase
    end

    assign overflow_err         = overflow_q;
    assign bus.enable_read_mode = enable_rd;
    assign bus.read_pause       = (FIFO_DEPTH - int'(fifo_level)) <= PAUSE_MARGIN;
    assign bus.pix_valid        = !fifo_empty;
    // Memory contents are not reset, so mask the head while the FIFO is empty.
    assign bus.pix_data         = fifo_empty ? '0 : fifo_rdata;
    assign bus.pix_x            = x_q;
    assign bus.pix_y            = y_q;
    assign bus.pix_last         = !fifo_empty && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader.
// dut_a: 4x2 frame, 8-deep FIFO, pause margin 2.
// dut_b: 4x4 frame, 8-deep FIFO, pause margin 2 (room for overflow cases).
module tb_sdram_frame_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0;
    logic done_a;
    logic ovf_a;
    logic start_b = 1'b0;
    logic done_b;
    logic ovf_b;

    sdram_frame_reader_if #(.DATA_WIDTH(16), .PIX_WIDTH(3)) ia ();
    sdram_frame_reader_if #(.DATA_WIDTH(16), .PIX_WIDTH(3)) ib ();

    sdram_frame_reader #(
        .IMG_WIDTH(4), .IMG_HEIGHT(2), .DATA_WIDTH(16), .PIX_WIDTH(3),
        .FIFO_DEPTH(8), .PAUSE_MARGIN(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start_reading(start_a),
        .reading_complete(done_a), .overflow_err(ovf_a), .bus(ia.master)
    );

    sdram_frame_reader #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_WIDTH(16), .PIX_WIDTH(3),
        .FIFO_DEPTH(8), .PAUSE_MARGIN(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start_reading(start_b),
        .reading_complete(done_b), .overflow_err(ovf_b), .bus(ib.master)
    );

    typedef struct packed {
        logic [2:0] d;
        logic [8:0] x;
        logic [7:0] y;
        logic       l;
    } pix_t;

    pix_t q_a[$];
    pix_t q_b[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_done_a = 0;
    int   n_done_b = 0;

    always @(posedge clk) begin
        if (ia.pix_valid && ia.pix_ready) q_a.push_back({ia.pix_data, ia.pix_x, ia.pix_y, ia.pix_last});
        if (ib.pix_valid && ib.pix_ready) q_b.push_back({ib.pix_data, ib.pix_x, ib.pix_y, ib.pix_last});
        if (done_a) n_done_a <= n_done_a + 1;
        if (done_b) n_done_b <= n_done_b + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required end of stimulus");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Expected capture entry for pixel position idx (4-pixel lines).
    function automatic logic [31:0] exp_pix(input int idx, input int dval, input int last_idx);
        pix_t p;
        p.d = 3'(dval);
        p.x = 9'(idx % 4);
        p.y = 8'(idx / 4);
        p.l = (idx == last_idx);
        return 32'(p);
    endfunction

    function automatic logic [31:0] outs_a();
        return 32'({ia.enable_read_mode, ia.read_pause, ia.pix_valid, ia.pix_data,
                    ia.pix_x, ia.pix_y, ia.pix_last, done_a, ovf_a});
    endfunction

    initial begin
        int base;
        ia.sdram_ready = 1'b0; ia.sdram_rx_valid = 1'b0; ia.sdram_rx_data = '0; ia.pix_ready = 1'b0;
        ib.sdram_ready = 1'b0; ib.sdram_rx_valid = 1'b0; ib.sdram_rx_data = '0; ib.pix_ready = 1'b0;

        // Power-on reset
        tick(); tick();
        check("reset_outputs", outs_a(), 32'd0);
        check("reset_ovf_b", 32'(ovf_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Gating: start without sdram_ready, strobes in IDLE
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("gate_no_ready_idle", 32'(ia.enable_read_mode), 32'd0);
        ia.sdram_ready = 1'b1;
        ia.sdram_rx_valid = 1'b1; ia.sdram_rx_data = 16'd5;
        tick();
        ia.sdram_rx_valid = 1'b0;
        tick();
        check("gate_idle_strobe", 32'(ia.pix_valid), 32'd0);

        // Reset in the middle of a frame
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("req_enable", 32'(ia.enable_read_mode), 32'd1);
        for (int i = 0; i < 3; i++) begin
            ia.sdram_rx_valid = 1'b1; ia.sdram_rx_data = 16'(10 + i);
            tick();
        end
        ia.sdram_rx_valid = 1'b0;
        check("stream_pix_valid", 32'(ia.pix_valid), 32'd1);
        check("stream_head_data", 32'(ia.pix_data), 32'd2);
        #2 rst_n = 1'b0;
        #1 check("midframe_reset_outputs", outs_a(), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        check("post_reset_idle", 32'({ia.enable_read_mode, ia.pix_valid}), 32'd0);
        check("post_reset_no_done", 32'(n_done_a), 32'd0);

        // Basic frame, consumer always ready, 9th strobe lands in DRAIN
        q_a.delete();
        ia.pix_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ia.sdram_rx_valid = 1'b1; ia.sdram_rx_data = 16'(i);
            tick();
            if (i == 6) check("enable_before_last", 32'(ia.enable_read_mode), 32'd1);
            if (i == 7) check("enable_after_last", 32'(ia.enable_read_mode), 32'd0);
        end
        ia.sdram_rx_valid = 1'b0;
        base = n_done_a;
        for (int t = 0; t < 30 && n_done_a == base; t++) tick();
        check("basic_done_pulse", 32'(n_done_a), 32'(base + 1));
        check("basic_count", 32'(q_a.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("basic_pix%0d", i),
                  (i < q_a.size()) ? 32'(q_a[i]) : 32'hFFFF_FFFF, exp_pix(i, i, 7));
        tick(); tick(); tick();
        check("basic_single_pulse", 32'(n_done_a), 32'(base + 1));

        // Backpressure: read_pause at level 6, ordered drain afterwards
        q_a.delete();
        ia.pix_ready = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ia.sdram_rx_valid = 1'b1; ia.sdram_rx_data = 16'h00A0 + 16'(i);
            tick();
            if (i == 4) check("pause_level5", 32'(ia.read_pause), 32'd0);
            if (i == 5) check("pause_level6", 32'(ia.read_pause), 32'd1);
        end
        ia.sdram_rx_valid = 1'b0;
        check("held_head_data", 32'({ia.pix_data, ia.pix_x, ia.pix_y}), 32'd0);
        ia.pix_ready = 1'b1;
        base = n_done_a;
        for (int t = 0; t < 30 && n_done_a == base; t++) tick();
        check("bp_done_pulse", 32'(n_done_a), 32'(base + 1));
        check("bp_count", 32'(q_a.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("bp_pix%0d", i),
                  (i < q_a.size()) ? 32'(q_a[i]) : 32'hFFFF_FFFF, exp_pix(i, i, 7));

        // Full FIFO with simultaneous push and pop
        q_b.delete();
        ib.sdram_ready = 1'b1;
        ib.pix_ready = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ib.sdram_rx_valid = 1'b1; ib.sdram_rx_data = 16'(i);
            tick();
        end
        check("full_pause", 32'(ib.read_pause), 32'd1);
        ib.sdram_rx_data = 16'd8;
        ib.pix_ready = 1'b1;
        tick();
        ib.sdram_rx_valid = 1'b0;
        check("pushpop_no_ovf", 32'(ovf_b), 32'd0);
        check("pushpop_head", 32'({ib.pix_data, ib.pix_x}), 32'({3'd1, 9'd1}));
        for (int t = 0; t < 8; t++) tick();
        check("pushpop_level8_drained", 32'({ib.pix_valid, 8'(q_b.size())}), 32'd9);
        for (int i = 9; i < 16; i++) begin
            ib.sdram_rx_valid = 1'b1; ib.sdram_rx_data = 16'(i);
            tick();
        end
        ib.sdram_rx_valid = 1'b0;
        base = n_done_b;
        for (int t = 0; t < 30 && n_done_b == base; t++) tick();
        check("pushpop_done", 32'(n_done_b), 32'(base + 1));
        check("pushpop_count", 32'(q_b.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("pushpop_pix%0d", i),
                  (i < q_b.size()) ? 32'(q_b[i]) : 32'hFFFF_FFFF, exp_pix(i, i, 15));

        // Overflow: 9 strobes into the 8-deep FIFO with the consumer stalled
        q_b.delete();
        ib.pix_ready = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("ovf_cleared_by_start", 32'(ovf_b), 32'd0);
        for (int i = 0; i < 9; i++) begin
            ib.sdram_rx_valid = 1'b1; ib.sdram_rx_data = 16'(i);
            tick();
            if (i == 7) check("ovf_at_full", 32'(ovf_b), 32'd0);
        end
        ib.sdram_rx_valid = 1'b0;
        check("ovf_set", 32'(ovf_b), 32'd1);
        ib.pix_ready = 1'b1;
        for (int t = 0; t < 12; t++) tick();
        check("ovf_first_count", 32'(q_b.size()), 32'd8);
        for (int i = 9; i < 16; i++) begin
            ib.sdram_rx_valid = 1'b1; ib.sdram_rx_data = 16'(i);
            tick();
        end
        ib.sdram_rx_valid = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        check("ovf_total_count", 32'(q_b.size()), 32'd15);
        for (int i = 0; i < 15; i++)
            check($sformatf("ovf_pix%0d", i),
                  (i < q_b.size()) ? 32'(q_b[i]) : 32'hFFFF_FFFF,
                  exp_pix(i, (i < 8) ? i : i + 1, 15));
        check("ovf_sticky", 32'(ovf_b), 32'd1);
        check("ovf_short_frame_no_done", 32'(n_done_b), 32'(base + 1));
        check("ovf_drain_enable", 32'(ib.enable_read_mode), 32'd0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        check("start_ignored_in_drain", 32'({ovf_b, ib.enable_read_mode}), 32'b10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("ovf_cleared_by_reset", 32'(ovf_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
